// File: rtl/scaler_scale2x.sv
// scaler_scale2x: streaming 2x pixel scaler (nearest / Scale2x; blend mode when SCALER_BLEND_EN is defined).
// Latency: block (x,y) is registered the cycle after pixel (x,y+1) is accepted; the last row drains in FLUSH.
// Backpressure: out_* held until out_ready; in_ready drops while a block is stalled (in_ready = !out_valid || out_ready).
module scaler_scale2x #(
  parameter int MAX_WIDTH = 512,
  parameter int PIXEL_W   = 16
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic                           cfg_start,
  input  logic [$clog2(MAX_WIDTH+1)-1:0] cfg_width,
  input  logic [9:0]                     cfg_height,
  input  logic [1:0]                     cfg_mode,
  input  logic                           cfg_565,
  output logic                           busy,
  input  logic [PIXEL_W-1:0]             in_pixel,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [2*PIXEL_W-1:0]           out_top,
  output logic [2*PIXEL_W-1:0]           out_bot,
  output logic [9:0]                     out_x,
  output logic [9:0]                     out_y,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_t;

  state_t             r_state;
  logic [9:0]         r_w_m1;     // width - 1
  logic [9:0]         r_h_m1;     // height - 1
  logic [9:0]         r_x;        // column of the block being built / pixel being stored
  logic [9:0]         r_y;        // row of the block being built
  logic [1:0]         r_mode;
  logic               r_sel;      // which line buffer holds row y (the P row)
  logic               r_flushed;  // final block has been emitted, waiting for its handshake
  logic [PIXEL_W-1:0] r_left;     // P of the previous column (A neighbour)

  // Two line buffers: one holds row y, the other row y-1 and is overwritten by row y+1
  logic [PIXEL_W-1:0] r_line0 [MAX_WIDTH];
  logic [PIXEL_W-1:0] r_line1 [MAX_WIDTH];

  logic               w_free;
  logic               w_in_acc;
  logic               w_emit;
  logic               w_xlast;
  logic               w_ylast;
  logic [AW-1:0]      w_xi;
  logic [AW-1:0]      w_xn;
  logic [PIXEL_W-1:0] w_p, w_pn, w_up;
  logic [PIXEL_W-1:0] w_a, w_b, w_c, w_d;
  logic [PIXEL_W-1:0] w_e0, w_e1, w_e2, w_e3;

`ifdef SCALER_BLEND_EN
  logic r_565;

  // Per-channel average: mask off each channel's LSB, halve, then add back the carry of both LSBs
  function automatic logic [PIXEL_W-1:0] f_avg(input logic [PIXEL_W-1:0] a,
                                                input logic [PIXEL_W-1:0] b,
                                                input logic               is565);
    logic [PIXEL_W-1:0] m;
    logic [PIXEL_W-1:0] l;
    m = is565 ? PIXEL_W'(16'hF7DE) : PIXEL_W'(16'h7BDE);
    l = is565 ? PIXEL_W'(16'h0821) : PIXEL_W'(16'h0421);
    if (a == b) return a;
    return ((a & m) >> 1) + ((b & m) >> 1) + (a & b & l);
  endfunction
`else
  // Colour masks only matter for blend mode, which is not built in
  logic w_unused_565;
  assign w_unused_565 = cfg_565;
`endif

  assign w_free   = !out_valid || out_ready;
  assign in_ready = (r_state == S_FILL) || ((r_state == S_RUN) && w_free);
  assign w_in_acc = in_valid && in_ready;
  assign w_emit   = ((r_state == S_RUN) && w_in_acc) ||
                    ((r_state == S_FLUSH) && w_free && !r_flushed);
  assign w_xlast  = (r_x == r_w_m1);
  assign w_ylast  = (r_y == r_h_m1);
  assign w_xi     = r_x[AW-1:0];
  assign w_xn     = w_xlast ? w_xi : w_xi + AW'(1);

  // Gather the centre pixel and its four neighbours, replicating P past the image edges
  always_comb begin
    w_p  = r_sel ? r_line1[w_xi] : r_line0[w_xi];
    w_pn = r_sel ? r_line1[w_xn] : r_line0[w_xn];
    w_up = r_sel ? r_line0[w_xi] : r_line1[w_xi];
    w_a  = (r_x == 10'd0) ? w_p : r_left;
    w_b  = (r_y == 10'd0) ? w_p : w_up;
    w_c  = w_xlast ? w_p : w_pn;
    w_d  = (r_state == S_RUN) ? in_pixel : w_p;
  end

  // Build the 2x2 output block for the selected mode; unknown modes fall back to nearest
  always_comb begin
    w_e0 = w_p;
    w_e1 = w_p;
    w_e2 = w_p;
    w_e3 = w_p;
    case (r_mode)
      2'd1: begin
        if ((w_b != w_d) && (w_a != w_c)) begin
          w_e0 = (w_a == w_b) ? w_a : w_p;
          w_e1 = (w_b == w_c) ? w_c : w_p;
          w_e2 = (w_a == w_d) ? w_a : w_p;
          w_e3 = (w_d == w_c) ? w_c : w_p;
        end
      end
`ifdef SCALER_BLEND_EN
      2'd2: begin
        w_e1 = f_avg(w_p, w_c, r_565);
        w_e2 = f_avg(w_p, w_d, r_565);
        w_e3 = f_avg(w_c, w_d, r_565);
      end
`endif
      default: ;
    endcase
  end

  // Line buffer writes: row 0 into the P buffer during FILL, row y+1 over the consumed B slot during RUN
  always_ff @(posedge CLK) begin
    if (w_in_acc && (r_state == S_FILL)) begin
      if (r_sel) r_line1[w_xi] <= in_pixel;
      else       r_line0[w_xi] <= in_pixel;
    end else if (w_in_acc && (r_state == S_RUN)) begin
      if (r_sel) r_line0[w_xi] <= in_pixel;
      else       r_line1[w_xi] <= in_pixel;
    end
  end

  // Control FSM with registered output block, coordinates and busy
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_w_m1    <= '0;
      r_h_m1    <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_mode    <= '0;
      r_sel     <= 1'b0;
      r_flushed <= 1'b0;
      r_left    <= '0;
`ifdef SCALER_BLEND_EN
      r_565     <= 1'b0;
`endif
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_top   <= '0;
      out_bot   <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_last  <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (w_emit) begin
        out_valid <= 1'b1;
        out_top   <= {w_e1, w_e0};
        out_bot   <= {w_e3, w_e2};
        out_x     <= r_x;
        out_y     <= r_y;
        out_last  <= w_xlast && w_ylast;
        r_left    <= w_p;
      end
      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            r_w_m1  <= 10'(cfg_width) - 10'd1;
            r_h_m1  <= cfg_height - 10'd1;
            r_mode  <= cfg_mode;
`ifdef SCALER_BLEND_EN
            r_565   <= cfg_565;
`endif
            r_x     <= '0;
            r_y     <= '0;
            r_sel   <= 1'b0;
            busy    <= 1'b1;
            r_state <= S_FILL;
          end
        end
        S_FILL: begin
          if (w_in_acc) begin
            if (w_xlast) begin
              r_x     <= '0;
              r_state <= (r_h_m1 != 10'd0) ? S_RUN : S_FLUSH;
            end else begin
              r_x <= r_x + 10'd1;
            end
          end
        end
        S_RUN: begin
          if (w_in_acc) begin
            if (w_xlast) begin
              r_x   <= '0;
              r_y   <= r_y + 10'd1;
              r_sel <= !r_sel;
              if ((r_y + 10'd1) == r_h_m1) r_state <= S_FLUSH;
            end else begin
              r_x <= r_x + 10'd1;
            end
          end
        end
        S_FLUSH: begin
          if (w_emit) begin
            if (w_xlast) r_flushed <= 1'b1;
            else         r_x <= r_x + 10'd1;
          end
          if (r_flushed && out_valid && out_ready) begin
            r_flushed <= 1'b0;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
